linescanner_capture_sequencer: RTL
==================================

// Module: linescanner_capture_sequencer
// PURPOSE
// Frame-level sequencer for the line-scanner-to-AXI-Stream convertor. Triggers each sensor line, gates the convertor
// enable, counts pixel_captured strobes and monitors the convertor's master stream (tvalid/tready/tlast) to confirm line
// completion. Repeats for cfg_lines_per_frame lines, then reports done. Flags config, timeout and protocol errors.
// PARAMETERS
// PIX_W            16        width of pixel counter / cfg_pixels_per_line
// LINE_W           16        width of line counter / cfg_lines_per_frame
// TRIG_CYCLES      4         sensor_line_trigger pulse length, clocks (>=1)
// TIMEOUT_CYCLES   1000000   watchdog limit in CAPTURE/DRAIN, clocks
// PORTS
// axi_aclk             in   1       clock
// axi_areset           in   1       synchronous, active-high reset
// start                in   1       1-cycle pulse: begin frame (IDLE) / clear error (ERROR)
// abort                in   1       level/pulse: stop frame, return to IDLE
// cfg_pixels_per_line  in   PIX_W   pixels per line, sampled on accepted start
// cfg_lines_per_frame  in   LINE_W  lines per frame, sampled on accepted start
// cfg_line_gap         in   16      idle clocks between lines, sampled on accepted start
// pixel_captured       in   1       sensor pixel strobe (same signal feeding the convertor)
// stream_tvalid        in   1       convertor m00_axis_tvalid (monitor only)
// stream_tready        in   1       downstream m00_axis_tready (monitor only)
// stream_tlast         in   1       convertor m00_axis_tlast (monitor only)
// sensor_line_trigger  out  1       line-start pulse to sensor
// conv_enable          out  1       convertor enable
// busy                 out  1       state != IDLE, DONE, ERROR
// frame_done           out  1       1-cycle pulse, frame complete
// line_count           out  LINE_W  lines completed in current/last frame
// error                out  1       sticky error flag
// err_code             out  2       0 none, 1 bad cfg, 2 timeout, 3 protocol
// BEHAVIOUR
// - All outputs registered; reset -> state IDLE, every output 0, counters 0.
// - beat = stream_tvalid & stream_tready; last_beat = beat & stream_tlast.
// - IDLE: start -> latch cfg, line_count<=0; if pixels==0 or lines==0 -> ERROR(code 1), else TRIGGER next clock.
// - TRIGGER: sensor_line_trigger=1 for exactly TRIG_CYCLES clocks, then CAPTURE; pixel counter cleared on entry.
// - conv_enable=1 in TRIGGER, CAPTURE, DRAIN; 0 elsewhere. start at cycle N -> trigger+conv_enable high from N+1.
// - CAPTURE: pixel_captured increments counter; when counter reaches cfg_pixels_per_line -> DRAIN.
//   last_beat in CAPTURE before final pixel -> ERROR(code 3). Final pixel and last_beat same clock -> line complete.
// - DRAIN: wait last_beat; pixel_captured in DRAIN -> ERROR(code 3) (overrun).
// - Line complete: line_count+1; if equals cfg_lines_per_frame -> DONE, else GAP.
// - GAP: hold cfg_line_gap clocks (0 -> TRIGGER on next clock), then TRIGGER.
// - DONE: frame_done=1 one clock, then IDLE; line_count holds until next accepted start.
// - Watchdog: reloads on entering CAPTURE/DRAIN, each pixel_captured, each beat; reaching TIMEOUT_CYCLES -> ERROR(2).
// - ERROR: error=1, err_code held, conv_enable=0, trigger=0; start -> clear error/err_code, IDLE (no frame begins).
// - abort: highest priority; any state except ERROR -> IDLE next clock, outputs deasserted, no frame_done, no error.
//   abort with start in IDLE: start ignored. In ERROR abort has no effect.
// - start while busy or in DONE: ignored. cfg changes mid-frame: ignored (latched copy used).
// - Reset mid-frame: immediate return to reset state on next clock edge, trigger truncated.
// - Counters compare with ==; no wrap: pixel counter never exceeds cfg value (overrun caught as error).
// TESTING
// 1 pixels=8, lines=3, gap=2, tready=1, tlast on 8th beat -> 3 trigger pulses of 4 clks, frame_done once, line_count=3.
// 2 start with lines=0 -> error=1, err_code=1, conv_enable never high; then start -> error=0, IDLE.
// 3 pixels=8, stop strobes after 5 -> err_code=2 exactly TIMEOUT_CYCLES (set to 64 in bench) after 5th strobe.
// 4 tlast beat after 6 of 8 pixels -> err_code=3; separately 9th strobe in DRAIN -> err_code=3.
// 5 abort during line 2 of 4 -> IDLE next clk, conv_enable=0, no frame_done, error=0; new start runs full frame.
// 6 8th pixel and last_beat same clock, tready toggling 50% -> no DRAIN state, line_count increments, frame completes.

Source files
------------

// File: rtl/linescanner_capture_sequencer.sv
// Frame sequencer for the line-scanner-to-AXI-Stream convertor.
// Triggers each sensor line, gates the convertor, counts pixel strobes and
// watches the convertor's output stream for the end-of-line beat. After the
// configured number of lines it reports done; config, timeout and stream
// protocol problems park the sequencer in a sticky error state.
module linescanner_capture_sequencer #(
  parameter int PIX_W          = 16,
  parameter int LINE_W         = 16,
  parameter int TRIG_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              start,
  input  logic              abort,
  input  logic [PIX_W-1:0]  cfg_pixels_per_line,
  input  logic [LINE_W-1:0] cfg_lines_per_frame,
  input  logic [15:0]       cfg_line_gap,
  input  logic              pixel_captured,
  input  logic              stream_tvalid,
  input  logic              stream_tready,
  input  logic              stream_tlast,
  output logic              sensor_line_trigger,
  output logic              conv_enable,
  output logic              busy,
  output logic              frame_done,
  output logic [LINE_W-1:0] line_count,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRIGGER = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  localparam logic [1:0] ERR_CFG     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_PROTO   = 2'd3;

  localparam int TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]        state_reg, state_next;
  logic [PIX_W-1:0]  pix_cfg_reg, pix_cfg_next;
  logic [LINE_W-1:0] lines_cfg_reg, lines_cfg_next;
  logic [15:0]       gap_cfg_reg, gap_cfg_next;
  logic [PIX_W-1:0]  pix_cnt_reg, pix_cnt_next;
  logic [LINE_W-1:0] line_cnt_reg, line_cnt_next;
  logic [15:0]       gap_cnt_reg, gap_cnt_next;
  logic [TRIG_W-1:0] trig_cnt_reg, trig_cnt_next;
  logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;
  logic [1:0]        err_code_reg, err_code_next;
  logic              trig_reg, conv_reg, busy_reg, done_reg, error_reg;

  logic              beat, last_beat, line_done;
  logic [PIX_W-1:0]  pix_inc;
  logic [LINE_W-1:0] line_inc;

  assign beat      = stream_tvalid & stream_tready;
  assign last_beat = beat & stream_tlast;
  assign pix_inc   = pix_cnt_reg + PIX_W'(1);
  assign line_inc  = line_cnt_reg + LINE_W'(1);

  // Next-state and counter logic; abort is applied last so it overrides all.
  always_comb begin
    state_next     = state_reg;
    pix_cfg_next   = pix_cfg_reg;
    lines_cfg_next = lines_cfg_reg;
    gap_cfg_next   = gap_cfg_reg;
    pix_cnt_next   = pix_cnt_reg;
    line_cnt_next  = line_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    trig_cnt_next  = trig_cnt_reg;
    wd_cnt_next    = wd_cnt_reg;
    err_code_next  = err_code_reg;
    line_done      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start && !abort) begin
          pix_cfg_next   = cfg_pixels_per_line;
          lines_cfg_next = cfg_lines_per_frame;
          gap_cfg_next   = cfg_line_gap;
          line_cnt_next  = '0;
          if ((cfg_pixels_per_line == '0) || (cfg_lines_per_frame == '0)) begin
            state_next    = S_ERROR;
            err_code_next = ERR_CFG;
          end else begin
            state_next    = S_TRIGGER;
            trig_cnt_next = '0;
            pix_cnt_next  = '0;
          end
        end
      end
      S_TRIGGER: begin
        if (trig_cnt_reg == TRIG_LAST) begin
          state_next  = S_CAPTURE;
          wd_cnt_next = '0;
        end else begin
          trig_cnt_next = trig_cnt_reg + TRIG_W'(1);
        end
      end
      S_CAPTURE: begin
        if (pixel_captured) begin
          pix_cnt_next = pix_inc;
          wd_cnt_next  = '0;
          if (pix_inc == pix_cfg_reg) begin
            // Final pixel and end-of-line beat together skip the drain phase.
            if (last_beat) line_done = 1'b1;
            else           state_next = S_DRAIN;
          end else if (last_beat) begin
            state_next    = S_ERROR;
            err_code_next = ERR_PROTO;
          end
        end else if (last_beat) begin
          state_next    = S_ERROR;
          err_code_next = ERR_PROTO;
        end else if (beat) begin
          wd_cnt_next = '0;
        end else if (wd_cnt_reg == WD_LAST) begin
          state_next    = S_ERROR;
          err_code_next = ERR_TIMEOUT;
        end else begin
          wd_cnt_next = wd_cnt_reg + WD_W'(1);
        end
      end
      S_DRAIN: begin
        if (pixel_captured) begin
          state_next    = S_ERROR;
          err_code_next = ERR_PROTO;
        end else if (last_beat) begin
          line_done = 1'b1;
        end else if (beat) begin
          wd_cnt_next = '0;
        end else if (wd_cnt_reg == WD_LAST) begin
          state_next    = S_ERROR;
          err_code_next = ERR_TIMEOUT;
        end else begin
          wd_cnt_next = wd_cnt_reg + WD_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == (gap_cfg_reg - 16'd1)) begin
          state_next    = S_TRIGGER;
          trig_cnt_next = '0;
          pix_cnt_next  = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      S_ERROR: begin
        if (start) begin
          state_next    = S_IDLE;
          err_code_next = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (line_done) begin
      line_cnt_next = line_inc;
      if (line_inc == lines_cfg_reg) begin
        state_next = S_DONE;
      end else if (gap_cfg_reg == 16'd0) begin
        state_next    = S_TRIGGER;
        trig_cnt_next = '0;
        pix_cnt_next  = '0;
      end else begin
        state_next   = S_GAP;
        gap_cnt_next = '0;
      end
    end

    if (abort && (state_reg != S_ERROR)) begin
      state_next    = S_IDLE;
      err_code_next = err_code_reg;
      line_cnt_next = line_cnt_reg;
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_reg     <= S_IDLE;
      pix_cfg_reg   <= '0;
      lines_cfg_reg <= '0;
      gap_cfg_reg   <= '0;
      pix_cnt_reg   <= '0;
      line_cnt_reg  <= '0;
      gap_cnt_reg   <= '0;
      trig_cnt_reg  <= '0;
      wd_cnt_reg    <= '0;
      err_code_reg  <= '0;
      trig_reg      <= 1'b0;
      conv_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pix_cfg_reg   <= pix_cfg_next;
      lines_cfg_reg <= lines_cfg_next;
      gap_cfg_reg   <= gap_cfg_next;
      pix_cnt_reg   <= pix_cnt_next;
      line_cnt_reg  <= line_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      trig_cnt_reg  <= trig_cnt_next;
      wd_cnt_reg    <= wd_cnt_next;
      err_code_reg  <= err_code_next;
      trig_reg      <= (state_next == S_TRIGGER);
      conv_reg      <= (state_next == S_TRIGGER) || (state_next == S_CAPTURE) ||
                       (state_next == S_DRAIN);
      busy_reg      <= (state_next != S_IDLE) && (state_next != S_DONE) &&
                       (state_next != S_ERROR);
      done_reg      <= (state_next == S_DONE);
      error_reg     <= (state_next == S_ERROR);
    end
  end

  assign sensor_line_trigger = trig_reg;
  assign conv_enable         = conv_reg;
  assign busy                = busy_reg;
  assign frame_done          = done_reg;
  assign line_count          = line_cnt_reg;
  assign error               = error_reg;
  assign err_code            = err_code_reg;

endmodule
